// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that pops bytes from an upstream FIFO (empty/read/data_out)
// and serializes them LSB-first on tx, one frame per fifo_read pulse.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read,
  output logic       tx,
  output logic       busy,
  output logic       byte_done,
  output logic [2:0] dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_START   = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_STOP    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          read_q, read_d;
  logic          done_q, done_d;
  logic          start_ok;
  logic          baud_last;

  // FIFO handshake: a byte is available when fifo_empty=0; one fifo_read pulse
  // pops it, and fifo_data holds that byte from the edge after the pulse.
  assign start_ok  = enable && !fifo_empty;
  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    read_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (start_ok) begin
          state_d = ST_READ;
          read_d  = 1'b1;
        end
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        shift_d = fifo_data;
        baud_d  = '0;
        tx_d    = 1'b0;
        state_d = ST_START;
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          done_d = 1'b1;
          tx_d   = 1'b1;
          // The end of the stop bit doubles as the idle decision so that
          // back-to-back frames are spaced 10*CLKS_PER_BIT+2 cycles apart.
          if (start_ok) begin
            state_d = ST_READ;
            read_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      read_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      read_q  <= read_d;
      done_q  <= done_d;
    end
  end

  assign fifo_read = read_q;
  assign tx        = tx_q;
  assign byte_done = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
